// File: rtl/mips_mem_pkg.sv
// Shared memory-side types for the MIPS cache/memory path: line geometry,
// write-buffer FSM states and the buffered-entry layout.
package mips_mem_pkg;

  localparam int LINE_ADDR_W = 28;
  localparam int LINE_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RD_MEM,
    RESP
  } wb_state_e;

  typedef struct packed {
    logic                   valid;
    logic [LINE_ADDR_W-1:0] addr;
    logic [LINE_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbuf_entry_array.sv
// Write-buffer storage: DEPTH entries with push/pop/coalesce write ports and
// an associative search that returns the youngest matching valid entry.
module wbuf_entry_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_en,
  input  logic [PTR_W-1:0]       push_idx,
  input  logic [LINE_ADDR_W-1:0] push_addr,
  input  logic [LINE_DATA_W-1:0] push_data,
  input  logic                   pop_en,
  input  logic [PTR_W-1:0]       pop_idx,
  input  logic                   cw_en,
  input  logic [PTR_W-1:0]       cw_idx,
  input  logic [LINE_DATA_W-1:0] cw_data,
  input  logic [PTR_W-1:0]       head_idx,
  input  logic                   excl_head,
  input  logic [LINE_ADDR_W-1:0] srch_addr,
  output logic                   srch_hit,
  output logic [PTR_W-1:0]       srch_idx,
  output logic [LINE_DATA_W-1:0] srch_data,
  output logic [LINE_ADDR_W-1:0] head_addr,
  output logic [LINE_DATA_W-1:0] head_data
);

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] scan_idx;

  // Walk from oldest (head) to youngest so the last match wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    srch_hit  = 1'b0;
    srch_idx  = '0;
    srch_data = '0;
    scan_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_idx + PTR_W'(k);
      if (entries_q[scan_idx].valid && (entries_q[scan_idx].addr == srch_addr) &&
          !(excl_head && (k == 0))) begin
        srch_hit  = 1'b1;
        srch_idx  = scan_idx;
        srch_data = entries_q[scan_idx].data;
      end
    end
  end

  assign head_addr = entries_q[head_idx].addr;
  assign head_data = entries_q[head_idx].data;

  // NOTE: only the valid bits are reset; addr/data are storage and are qualified by valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      if (pop_en)  entries_q[pop_idx].valid <= 1'b0;
      if (cw_en)   entries_q[cw_idx].data   <= cw_data;
      // Push after pop: when full, tail==head and the same-edge push must survive.
      if (push_en) entries_q[push_idx]      <= '{valid: 1'b1, addr: push_addr, data: push_data};
    end
  end

endmodule

// File: rtl/d_write_buffer.sv
// Posted-write buffer between the D-cache and slow_memD: absorbs write-backs,
// drains them in the background, serves read hits and lets read misses bypass.
module d_write_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = LINE_ADDR_W,
  parameter int DATA_W = LINE_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [DATA_W-1:0] cache_wdata,
  output logic [DATA_W-1:0] cache_rdata,
  output logic              cache_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wb_empty
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  wb_state_e         state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              cache_ready_q, cache_ready_d;
  logic [DATA_W-1:0] cache_rdata_q, cache_rdata_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_empty_q, wb_empty_d;

  logic              push_en, pop_en, cw_en, srch_hit, req_ok, full;
  logic [PTR_W-1:0]  srch_idx;
  logic [DATA_W-1:0] srch_data, head_data;
  logic [ADDR_W-1:0] head_addr;

  wbuf_entry_array #(.DEPTH(DEPTH)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_en   (push_en),
    .push_idx  (tail_q),
    .push_addr (cache_addr),
    .push_data (cache_wdata),
    .pop_en    (pop_en),
    .pop_idx   (head_q),
    .cw_en     (cw_en),
    .cw_idx    (srch_idx),
    .cw_data   (cache_wdata),
    .head_idx  (head_q),
    .excl_head (state_q == DRAIN),
    .srch_addr (cache_addr),
    .srch_hit  (srch_hit),
    .srch_idx  (srch_idx),
    .srch_data (srch_data),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  // While cache_ready is high the cache still presents the request just served.
  assign req_ok = !cache_ready_q;
  assign full   = (count_q == FULL_CNT);

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    cache_ready_d = 1'b0;
    cache_rdata_d = cache_rdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    push_en       = 1'b0;
    pop_en        = 1'b0;
    cw_en         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_ok && cache_read) begin
          if (srch_hit) begin
            cache_rdata_d = srch_data;
            cache_ready_d = 1'b1;
            state_d       = RESP;
          end else begin
            mem_read_d = 1'b1;
            mem_addr_d = cache_addr;
            state_d    = RD_MEM;
          end
        end else if (req_ok && cache_write && (srch_hit || !full)) begin
          cw_en         = srch_hit;
          push_en       = !srch_hit;
          cache_ready_d = 1'b1;
          state_d       = RESP;
        end else if (count_q != '0) begin
          // Also taken when a write is stalled on a full buffer.
          mem_write_d = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          pop_en      = 1'b1;
          head_d      = head_q + PTR_W'(1);
          mem_write_d = 1'b0;
          state_d     = IDLE;
        end
        if (req_ok && cache_write && (srch_hit || !full || mem_ready)) begin
          cw_en         = srch_hit;
          push_en       = !srch_hit;
          cache_ready_d = 1'b1;
        end
      end
      RD_MEM: begin
        if (mem_ready) begin
          cache_rdata_d = mem_rdata;
          mem_read_d    = 1'b0;
          cache_ready_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (push_en) tail_d = tail_q + PTR_W'(1);
    count_d    = count_q + {{PTR_W{1'b0}}, push_en} - {{PTR_W{1'b0}}, pop_en};
    wb_empty_d = (count_d == '0) && (state_d != DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      cache_ready_q <= 1'b0;
      cache_rdata_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wb_empty_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      cache_ready_q <= cache_ready_d;
      cache_rdata_q <= cache_rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_empty_q    <= wb_empty_d;
    end
  end

  assign cache_ready = cache_ready_q;
  assign cache_rdata = cache_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_empty    = wb_empty_q;

endmodule

// File: tb/tb_d_write_buffer.sv
// Directed bench for d_write_buffer: a latency-programmable slow memory model
// logs every completed access; expectations are hand-computed per scenario.
module tb_d_write_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cache_read, cache_write;
  logic [27:0]  cache_addr;
  logic [127:0] cache_wdata, cache_rdata;
  logic         cache_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
  logic         wb_empty;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mem_lat = 3;
  int lat_cnt = 0;
  bit both_seen = 1'b0;

  // Completed memory accesses, in order.
  bit           ev_wr   [$];
  logic [27:0]  ev_addr [$];
  logic [127:0] ev_data [$];
  int           ev_cyc  [$];

  d_write_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cache_read  (cache_read),
    .cache_write (cache_write),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_rdata (cache_rdata),
    .cache_ready (cache_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .wb_empty    (wb_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slow memory: answers after mem_lat cycles with a one-cycle mem_ready pulse.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) both_seen = 1'b1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        lat_cnt   = 0;
      end else if (!rst_n || !(mem_read || mem_write)) begin
        lat_cnt = 0;
      end else if (lat_cnt >= mem_lat - 1) begin
        mem_ready = 1'b1;
        mem_rdata = {4{{4'h0, mem_addr}}};
        ev_wr.push_back(mem_write);
        ev_addr.push_back(mem_addr);
        ev_data.push_back(mem_wdata);
        ev_cyc.push_back(cyc);
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end
  end

  task automatic do_write(input logic [27:0] a, input logic [127:0] d, output int lat, output int at);
    int start;
    bit got;
    start = cyc;
    got   = 1'b0;
    cache_addr  = a;
    cache_wdata = d;
    cache_write = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk); #1;
      if (cache_ready) got = 1'b1;
    end
    lat = cyc - start;
    at  = cyc;
    check("wr_done", {127'd0, got}, 128'd1);
    @(posedge clk); #1;
    cache_write = 1'b0;
  endtask

  task automatic do_read(input logic [27:0] a, output logic [127:0] d, output int lat, output int at);
    int start;
    bit got;
    start = cyc;
    got   = 1'b0;
    d     = '0;
    cache_addr = a;
    cache_read = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk); #1;
      if (cache_ready) begin
        got = 1'b1;
        d   = cache_rdata;
      end
    end
    lat = cyc - start;
    at  = cyc;
    check("rd_done", {127'd0, got}, 128'd1);
    @(posedge clk); #1;
    cache_read = 1'b0;
  endtask

  task automatic wait_empty();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(posedge clk); #1;
      if (wb_empty && !mem_write && !mem_read) got = 1'b1;
    end
    check("empty_to", {127'd0, got}, 128'd1);
  endtask

  task automatic wait_mem_write();
    bit got;
    got = mem_write;
    for (int n = 0; n < 50 && !got; n++) begin
      @(posedge clk); #1;
      if (mem_write) got = 1'b1;
    end
    check("mwr_to", {127'd0, got}, 128'd1);
  endtask

  initial begin
    int lat, at, at5, b;
    logic [127:0] rd;
    $timeformat(-9, 0, " ns", 8);
    rst_n = 1'b0; cache_read = 1'b0; cache_write = 1'b0;
    cache_addr = '0; cache_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {127'd0, cache_ready}, 128'd0);
    check("rst_mrd",   {127'd0, mem_read},    128'd0);
    check("rst_mwr",   {127'd0, mem_write},   128'd0);
    check("rst_maddr", {100'd0, mem_addr},    128'd0);
    check("rst_mwdat", mem_wdata,             128'd0);
    check("rst_rdata", cache_rdata,           128'd0);
    check("rst_empty", {127'd0, wb_empty},    128'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single write, fast ack, background drain.
    b = ev_wr.size();
    do_write(28'h0000010, 128'hA, lat, at);
    check("t1_lat", lat, 1);
    wait_mem_write();
    check("t1_maddr", {100'd0, mem_addr}, 128'h10);
    check("t1_mwdat", mem_wdata, 128'hA);
    @(posedge clk); #1;
    check("t1_hold", {127'd0, mem_write}, 128'd1);
    wait_empty();
    check("t1_nev", ev_wr.size() - b, 1);
    check("t1_ev", {ev_wr[b], ev_addr[b], ev_data[b]}, {1'b1, 28'h10, 128'hA});

    // 2: read hit on a buffered write, no memory read.
    b = ev_wr.size();
    do_write(28'h0000020, 128'hB, lat, at);
    do_read(28'h0000020, rd, lat, at);
    check("t2_lat", lat, 1);
    check("t2_data", rd, 128'hB);
    wait_empty();
    check("t2_nev", ev_wr.size() - b, 1);
    check("t2_ev", {ev_wr[b], ev_addr[b], ev_data[b]}, {1'b1, 28'h20, 128'hB});

    // 3: coalesce two writes to the same line.
    b = ev_wr.size();
    do_write(28'h0000030, 128'hC, lat, at);
    do_write(28'h0000030, 128'hD, lat, at);
    check("t3_lat", lat, 1);
    wait_empty();
    check("t3_nev", ev_wr.size() - b, 1);
    check("t3_ev", {ev_wr[b], ev_addr[b], ev_data[b]}, {1'b1, 28'h30, 128'hD});

    // 4: overflow with slow memory; 5th and 6th writes each wait for a pop.
    mem_lat = 8;
    b = ev_wr.size();
    for (int i = 0; i < 4; i++) begin
      do_write(28'h100 + 28'(i * 16), 128'h1000 + 128'(i), lat, at);
      check("t4_fill_lat", lat, 1);
    end
    do_write(28'h140, 128'h1004, lat, at5);
    do_write(28'h150, 128'h1005, lat, at);
    check("t4_nev_mid", ev_wr.size() - b, 2);
    check("t4_at5", at5, ev_cyc[b] + 1);
    check("t4_at6", at, ev_cyc[b+1] + 1);
    wait_empty();
    check("t4_nev", ev_wr.size() - b, 6);
    for (int i = 0; i < 6; i++) begin
      check("t4_ev", {ev_wr[b+i], ev_addr[b+i], ev_data[b+i]},
            {1'b1, 28'h100 + 28'(i * 16), 128'h1000 + 128'(i)});
    end

    // 5: read miss bypasses pending writes.
    mem_lat = 3;
    b = ev_wr.size();
    do_write(28'h0000040, 128'hE, lat, at);
    do_write(28'h0000050, 128'hF, lat, at);
    do_read(28'h0000060, rd, lat, at);
    check("t5_first", {ev_wr[b], ev_addr[b]}, {1'b0, 28'h60});
    check("t5_data", rd, 128'h00000060_00000060_00000060_00000060);
    check("t5_at", at, ev_cyc[b] + 1);
    wait_empty();
    check("t5_nev", ev_wr.size() - b, 3);
    check("t5_ev1", {ev_wr[b+1], ev_addr[b+1], ev_data[b+1]}, {1'b1, 28'h40, 128'hE});
    check("t5_ev2", {ev_wr[b+2], ev_addr[b+2], ev_data[b+2]}, {1'b1, 28'h50, 128'hF});

    // 6: reset in the middle of a drain.
    mem_lat = 20;
    do_write(28'h0000070, 128'h77, lat, at);
    wait_mem_write();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_mwr",   {127'd0, mem_write},   128'd0);
    check("t6_empty", {127'd0, wb_empty},    128'd1);
    check("t6_ready", {127'd0, cache_ready}, 128'd0);
    @(posedge clk); #1;
    check("t6_ready2", {127'd0, cache_ready}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    check("excl_rw", {127'd0, both_seen}, 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
